// File: rtl/rpn_kip_tx_pkg.sv
// KIP reliability definitions shared by the KIP tx/rx blocks: field widths,
// PUB header layout, retry defaults and the tx FSM state encoding.
package rpn_kip_tx_pkg;

  localparam int AXIS_DATA_WIDTH                = 512;
  localparam int AXIS_KEEP_WIDTH                = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_WAN_TDEST_WIDTH           = 32;
  localparam int IP_ADDRESS_WIDTH               = 32;
  localparam int AXIS_KIP_TUSER_DEST_PORT_WIDTH = 16;
  localparam int AXIS_KIP_TUSER_SRC_PORT_WIDTH  = 16;
  localparam int AXIS_KIP_TUSER_WIDTH           = IP_ADDRESS_WIDTH +
                                                  AXIS_KIP_TUSER_DEST_PORT_WIDTH +
                                                  AXIS_KIP_TUSER_SRC_PORT_WIDTH;
  localparam int RPN_MSG_TYPE_WIDTH             = 8;
  localparam int WAN_SEQUENCE_NUMBER_WIDTH      = 32;

  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_KIP_PUB = 8'h03;

  // PUB header: type | sender CTID | sequence number | payload
  localparam int PUB_KIP_SENDER_CTID_OFFSET     = RPN_MSG_TYPE_WIDTH;
  localparam int PUB_KIP_SEQUENCE_NUMBER_OFFSET = PUB_KIP_SENDER_CTID_OFFSET + AXIS_WAN_TDEST_WIDTH;
  localparam int PUB_KIP_DATA_OFFSET            = 128;
  localparam int PUB_KIP_DATA_WIDTH             = AXIS_DATA_WIDTH - PUB_KIP_DATA_OFFSET;

  localparam int RETRY_DELAY_DEFAULT = 16;
  localparam int MAX_RETRIES_DEFAULT = 255;

  typedef enum logic [2:0] {
    KIP_TX_IDLE,
    KIP_TX_REQ,
    KIP_TX_WAIT_SEQ,
    KIP_TX_BACKOFF,
    KIP_TX_SEND
  } kip_tx_state_e;

  typedef struct packed {
    logic [AXIS_KIP_TUSER_SRC_PORT_WIDTH-1:0]  src_port;
    logic [AXIS_KIP_TUSER_DEST_PORT_WIDTH-1:0] dest_port;
    logic [IP_ADDRESS_WIDTH-1:0]               ip;
  } kip_tuser_t;

  function automatic logic [AXIS_DATA_WIDTH-1:0] pub_pack(
    input logic [AXIS_WAN_TDEST_WIDTH-1:0]      ctid,
    input logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] seq,
    input logic [PUB_KIP_DATA_WIDTH-1:0]        payload
  );
    logic [AXIS_DATA_WIDTH-1:0] pub;
    pub = '0;
    pub[RPN_MSG_TYPE_WIDTH-1:0]                                     = RPN_MSG_TYPE_KIP_PUB;
    pub[PUB_KIP_SENDER_CTID_OFFSET +: AXIS_WAN_TDEST_WIDTH]         = ctid;
    pub[PUB_KIP_SEQUENCE_NUMBER_OFFSET +: WAN_SEQUENCE_NUMBER_WIDTH] = seq;
    pub[PUB_KIP_DATA_OFFSET +: PUB_KIP_DATA_WIDTH]                  = payload;
    return pub;
  endfunction

endpackage

// File: rtl/rpn_kip_tx.sv
// KIP transmit: takes a control message, obtains a per-destination sequence
// number from WNN (with backoff/retry on refusal) and emits a PUB packet.
module rpn_kip_tx
  import rpn_kip_tx_pkg::*;
#(
  parameter int RETRY_DELAY = RETRY_DELAY_DEFAULT,
  parameter int MAX_RETRIES = MAX_RETRIES_DEFAULT
) (
  input  logic                                      i_clk,
  input  logic                                      i_ap_rst_n,
  input  logic [AXIS_WAN_TDEST_WIDTH-1:0]           i_cluster_id,
  input  logic [AXIS_KIP_TUSER_DEST_PORT_WIDTH-1:0] i_KIP_port_number,

  input  logic                                      from_ctrl_tvalid,
  output logic                                      from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]                from_ctrl_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]                from_ctrl_tkeep,
  input  logic                                      from_ctrl_tlast,
  input  logic [AXIS_WAN_TDEST_WIDTH-1:0]           from_ctrl_tdest,
  input  logic [AXIS_KIP_TUSER_WIDTH-1:0]           from_ctrl_tuser,

  output logic                                      to_WNN_tvalid,
  input  logic                                      to_WNN_tready,
  output logic [RPN_MSG_TYPE_WIDTH-1:0]             to_WNN_tdata,
  output logic [AXIS_WAN_TDEST_WIDTH-1:0]           to_WNN_tdest,

  input  logic                                      from_WNN_tvalid,
  output logic                                      from_WNN_tready,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0]      from_WNN_tdata,
  input  logic [AXIS_WAN_TDEST_WIDTH-1:0]           from_WNN_tdest,
  input  logic                                      from_WNN_tuser,

  output logic                                      to_nb_KIP_tvalid,
  input  logic                                      to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH-1:0]                to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                to_nb_KIP_tkeep,
  output logic [AXIS_KIP_TUSER_WIDTH-1:0]           to_nb_KIP_tuser,
  output logic                                      to_nb_KIP_tlast,

  output logic                                      o_drop
);

  localparam int RC_W = $clog2(MAX_RETRIES + 1);
  localparam int BO_W = $clog2(RETRY_DELAY + 1);
  localparam logic [RC_W-1:0] RETRY_LAST   = RC_W'(MAX_RETRIES - 1);
  localparam logic [BO_W-1:0] BACKOFF_LAST = BO_W'(RETRY_DELAY - 1);

  kip_tx_state_e                 state, state_nxt;
  logic                          drop_nxt;
  logic [PUB_KIP_DATA_WIDTH-1:0] msg_q;
  logic [IP_ADDRESS_WIDTH-1:0]   ip_q;
  logic [RC_W-1:0]               retry_cnt;
  logic [BO_W-1:0]               bo_cnt;
  kip_tuser_t                    pub_tuser;

  logic ctrl_hs, req_hs, grant_hs, pub_hs;
  assign ctrl_hs  = from_ctrl_tvalid & from_ctrl_tready;
  assign req_hs   = to_WNN_tvalid & to_WNN_tready;
  assign grant_hs = from_WNN_tvalid & from_WNN_tready;
  assign pub_hs   = to_nb_KIP_tvalid & to_nb_KIP_tready;

  // Inputs deliberately not consumed: single-beat framing, discarded payload
  // tail, upper tuser bits, and the grant CTID (only one request in flight).
  logic unused_bits;
  assign unused_bits = ^{from_ctrl_tdata[AXIS_DATA_WIDTH-1:PUB_KIP_DATA_WIDTH], from_ctrl_tkeep,
                         from_ctrl_tlast, from_ctrl_tuser[AXIS_KIP_TUSER_WIDTH-1:IP_ADDRESS_WIDTH],
                         from_WNN_tdest};

  assign pub_tuser = '{src_port: i_KIP_port_number, dest_port: i_KIP_port_number, ip: ip_q};

  always_comb begin
    state_nxt = state;
    drop_nxt  = 1'b0;
    case (state)
      KIP_TX_IDLE:     if (ctrl_hs) state_nxt = KIP_TX_REQ;
      KIP_TX_REQ:      if (req_hs)  state_nxt = KIP_TX_WAIT_SEQ;
      KIP_TX_WAIT_SEQ: if (grant_hs) begin
        if (from_WNN_tuser) begin
          state_nxt = KIP_TX_SEND;
        end else if (retry_cnt == RETRY_LAST) begin
          state_nxt = KIP_TX_IDLE;
          drop_nxt  = 1'b1;
        end else begin
          state_nxt = KIP_TX_BACKOFF;
        end
      end
      KIP_TX_BACKOFF:  if (bo_cnt == BACKOFF_LAST) state_nxt = KIP_TX_REQ;
      KIP_TX_SEND:     if (pub_hs) state_nxt = KIP_TX_IDLE;
      default:         state_nxt = KIP_TX_IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state            <= KIP_TX_IDLE;
      from_ctrl_tready <= 1'b0;
      to_WNN_tvalid    <= 1'b0;
      from_WNN_tready  <= 1'b0;
      to_nb_KIP_tvalid <= 1'b0;
      o_drop           <= 1'b0;
    end else begin
      state            <= state_nxt;
      from_ctrl_tready <= (state_nxt == KIP_TX_IDLE);
      to_WNN_tvalid    <= (state_nxt == KIP_TX_REQ);
      from_WNN_tready  <= (state_nxt == KIP_TX_WAIT_SEQ);
      to_nb_KIP_tvalid <= (state_nxt == KIP_TX_SEND);
      o_drop           <= drop_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      msg_q        <= '0;
      ip_q         <= '0;
      to_WNN_tdata <= '0;
      to_WNN_tdest <= '0;
      retry_cnt    <= '0;
    end else if (ctrl_hs) begin
      msg_q        <= from_ctrl_tdata[PUB_KIP_DATA_WIDTH-1:0];
      ip_q         <= from_ctrl_tuser[IP_ADDRESS_WIDTH-1:0];
      to_WNN_tdata <= RPN_MSG_TYPE_KIP_PUB;
      to_WNN_tdest <= from_ctrl_tdest;
      retry_cnt    <= '0;
    end else if (grant_hs && !from_WNN_tuser) begin
      retry_cnt    <= retry_cnt + RC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n)               bo_cnt <= '0;
    else if (state == KIP_TX_BACKOFF) bo_cnt <= bo_cnt + BO_W'(1);
    else                           bo_cnt <= '0;
  end

  // The packet is frozen at grant so it stays stable under backpressure even
  // if the cluster id or port inputs move.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      to_nb_KIP_tdata <= '0;
      to_nb_KIP_tuser <= '0;
      to_nb_KIP_tkeep <= '0;
      to_nb_KIP_tlast <= 1'b0;
    end else if (grant_hs && from_WNN_tuser) begin
      to_nb_KIP_tdata <= pub_pack(i_cluster_id, from_WNN_tdata, msg_q);
      to_nb_KIP_tuser <= pub_tuser;
      to_nb_KIP_tkeep <= '1;
      to_nb_KIP_tlast <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rpn_kip_tx.sv
// Bench for rpn_kip_tx: table-driven scenarios, a mid-transaction reset and
// randomized messages, all checked against a shift/OR packet model.
module tb_rpn_kip_tx;
  import rpn_kip_tx_pkg::*;

  localparam int RD = 16;
  localparam int MR = 3;
  localparam logic [31:0] CLUSTER = 32'hEAEAEAEA;
  localparam logic [15:0] PORT    = 16'hFB;

  logic i_clk = 1'b0;
  logic i_ap_rst_n;
  logic [AXIS_WAN_TDEST_WIDTH-1:0]      i_cluster_id;
  logic [AXIS_KIP_TUSER_DEST_PORT_WIDTH-1:0] i_KIP_port_number;
  logic from_ctrl_tvalid, from_ctrl_tready, from_ctrl_tlast;
  logic [AXIS_DATA_WIDTH-1:0]           from_ctrl_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]           from_ctrl_tkeep;
  logic [AXIS_WAN_TDEST_WIDTH-1:0]      from_ctrl_tdest;
  logic [AXIS_KIP_TUSER_WIDTH-1:0]      from_ctrl_tuser;
  logic to_WNN_tvalid, to_WNN_tready;
  logic [RPN_MSG_TYPE_WIDTH-1:0]        to_WNN_tdata;
  logic [AXIS_WAN_TDEST_WIDTH-1:0]      to_WNN_tdest;
  logic from_WNN_tvalid, from_WNN_tready, from_WNN_tuser;
  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] from_WNN_tdata;
  logic [AXIS_WAN_TDEST_WIDTH-1:0]      from_WNN_tdest;
  logic to_nb_KIP_tvalid, to_nb_KIP_tready, to_nb_KIP_tlast;
  logic [AXIS_DATA_WIDTH-1:0]           to_nb_KIP_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]           to_nb_KIP_tkeep;
  logic [AXIS_KIP_TUSER_WIDTH-1:0]      to_nb_KIP_tuser;
  logic o_drop;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  always #5 i_clk = ~i_clk;

  rpn_kip_tx #(.RETRY_DELAY(RD), .MAX_RETRIES(MR)) dut (
    .i_clk(i_clk), .i_ap_rst_n(i_ap_rst_n),
    .i_cluster_id(i_cluster_id), .i_KIP_port_number(i_KIP_port_number),
    .from_ctrl_tvalid(from_ctrl_tvalid), .from_ctrl_tready(from_ctrl_tready),
    .from_ctrl_tdata(from_ctrl_tdata), .from_ctrl_tkeep(from_ctrl_tkeep),
    .from_ctrl_tlast(from_ctrl_tlast), .from_ctrl_tdest(from_ctrl_tdest),
    .from_ctrl_tuser(from_ctrl_tuser),
    .to_WNN_tvalid(to_WNN_tvalid), .to_WNN_tready(to_WNN_tready),
    .to_WNN_tdata(to_WNN_tdata), .to_WNN_tdest(to_WNN_tdest),
    .from_WNN_tvalid(from_WNN_tvalid), .from_WNN_tready(from_WNN_tready),
    .from_WNN_tdata(from_WNN_tdata), .from_WNN_tdest(from_WNN_tdest),
    .from_WNN_tuser(from_WNN_tuser),
    .to_nb_KIP_tvalid(to_nb_KIP_tvalid), .to_nb_KIP_tready(to_nb_KIP_tready),
    .to_nb_KIP_tdata(to_nb_KIP_tdata), .to_nb_KIP_tkeep(to_nb_KIP_tkeep),
    .to_nb_KIP_tuser(to_nb_KIP_tuser), .to_nb_KIP_tlast(to_nb_KIP_tlast),
    .o_drop(o_drop)
  );

  typedef struct {
    logic [31:0]  tdest;
    logic [31:0]  ip;
    logic [511:0] data;
    int           refuse;   // refusals WNN gives before granting
    logic [31:0]  seq;
    int           stall;    // cycles the network bridge holds tready low
    int           exp_req;
    bit           exp_drop;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(negedge i_clk);
    ncyc++;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model_pub(input logic [31:0] seq, input logic [511:0] msg);
    logic [511:0] r;
    r = msg << PUB_KIP_DATA_OFFSET;
    r = r | ({480'd0, seq} << PUB_KIP_SEQUENCE_NUMBER_OFFSET)
          | ({480'd0, CLUSTER} << PUB_KIP_SENDER_CTID_OFFSET)
          | {504'd0, RPN_MSG_TYPE_KIP_PUB};
    return r;
  endfunction

  function automatic logic [63:0] model_tuser(input logic [31:0] ip);
    return ({48'd0, PORT} << 48) | ({48'd0, PORT} << 32) | {32'd0, ip};
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_ctrl_tready", 512'(from_ctrl_tready), 512'(0));
    chk("rst_wnn_req", 512'({to_WNN_tvalid, to_WNN_tdata, to_WNN_tdest}), 512'(0));
    chk("rst_wnn_tready", 512'(from_WNN_tready), 512'(0));
    chk("rst_nb_valid", 512'({to_nb_KIP_tvalid, to_nb_KIP_tlast, to_nb_KIP_tkeep}), 512'(0));
    chk("rst_nb_data", 512'({to_nb_KIP_tdata, to_nb_KIP_tuser}), 512'(0));
    chk("rst_drop", 512'(o_drop), 512'(0));
  endtask

  task automatic xact(input vec_t v);
    int  h, g, nreq, hold, wdly;
    bit  ok, granted, dropped, lock, busy_bad, stable;
    logic [511:0] d0;
    logic [63:0]  u0;
    nreq = 0; g = 0; granted = 0; dropped = 0; busy_bad = 0;
    from_ctrl_tvalid = 1'b1;
    from_ctrl_tdata  = v.data;
    from_ctrl_tdest  = v.tdest;
    from_ctrl_tuser  = {$urandom(), v.ip};
    from_ctrl_tkeep  = {$urandom(), $urandom()};
    from_ctrl_tlast  = 1'($urandom());
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) if (from_ctrl_tready) ok = 1; else tick();
    chk("ctrl_accept", 512'(ok), 512'(1));
    if (!ok) begin from_ctrl_tvalid = 1'b0; return; end
    h = ncyc;
    tick();
    from_ctrl_tvalid = 1'b0;

    while (!granted && !dropped && nreq < 8) begin
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        if (to_WNN_tvalid) ok = 1;
        else begin busy_bad |= from_ctrl_tready; tick(); end
      end
      chk("wnn_req_seen", 512'(ok), 512'(1));
      if (!ok) break;
      nreq++;
      chk("wnn_req_cycle", 512'(ncyc), 512'(nreq == 1 ? h + 1 : g + 1 + RD));
      chk("wnn_req_fields", 512'({to_WNN_tdata, to_WNN_tdest}), 512'({RPN_MSG_TYPE_KIP_PUB, v.tdest}));
      chk("wnn_rdy_in_req", 512'(from_WNN_tready), 512'(0));
      hold = $urandom_range(0, 2);
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        tick();
        stable &= to_WNN_tvalid && (to_WNN_tdest == v.tdest);
      end
      chk("wnn_req_hold", 512'(stable), 512'(1));
      to_WNN_tready = 1'b1;
      tick();
      to_WNN_tready = 1'b0;
      wdly = $urandom_range(0, 2);
      for (int i = 0; i < wdly; i++) begin busy_bad |= from_ctrl_tready; tick(); end
      lock = (nreq > v.refuse);
      from_WNN_tvalid = 1'b1;
      from_WNN_tuser  = lock;
      from_WNN_tdata  = lock ? v.seq : $urandom();
      from_WNN_tdest  = v.tdest;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) if (from_WNN_tready) ok = 1; else tick();
      chk("wnn_grant_taken", 512'(ok), 512'(1));
      if (!ok) begin from_WNN_tvalid = 1'b0; break; end
      g = ncyc;
      tick();
      from_WNN_tvalid = 1'b0;
      if (lock) granted = 1;
      else begin
        chk("drop_pulse", 512'(o_drop), 512'(v.exp_drop && nreq == v.exp_req));
        dropped = o_drop;
      end
    end

    chk("wnn_req_count", 512'(nreq), 512'(v.exp_req));
    chk("drop_seen", 512'(dropped), 512'(v.exp_drop));
    chk("ctrl_rdy_busy", 512'(busy_bad), 512'(0));
    if (dropped) begin
      chk("drop_to_idle", 512'(from_ctrl_tready), 512'(1));
      tick();
      chk("drop_one_cycle", 512'(o_drop), 512'(0));
      stable = 1;
      for (int i = 0; i < 4; i++) begin
        stable &= !to_nb_KIP_tvalid && !to_WNN_tvalid;
        tick();
      end
      chk("drop_quiet", 512'(stable), 512'(1));
    end else if (granted) begin
      chk("nb_valid_next", 512'(to_nb_KIP_tvalid), 512'(1));
      d0 = to_nb_KIP_tdata;
      u0 = to_nb_KIP_tuser;
      stable = 1;
      for (int i = 0; i < v.stall; i++) begin
        tick();
        stable &= to_nb_KIP_tvalid && (to_nb_KIP_tdata == d0) && (to_nb_KIP_tuser == u0) && !from_ctrl_tready;
      end
      if (v.stall > 0) chk("nb_hold_stable", 512'(stable), 512'(1));
      chk("pub_tdata", to_nb_KIP_tdata, model_pub(v.seq, v.data));
      chk("pub_seq_field", 512'(to_nb_KIP_tdata[PUB_KIP_SEQUENCE_NUMBER_OFFSET +: WAN_SEQUENCE_NUMBER_WIDTH]), 512'(v.seq));
      chk("pub_tuser", 512'(to_nb_KIP_tuser), 512'(model_tuser(v.ip)));
      chk("pub_keep_last", 512'({to_nb_KIP_tkeep, to_nb_KIP_tlast}), 512'({{AXIS_KEEP_WIDTH{1'b1}}, 1'b1}));
      to_nb_KIP_tready = 1'b1;
      tick();
      to_nb_KIP_tready = 1'b0;
      chk("nb_released", 512'(to_nb_KIP_tvalid), 512'(0));
      chk("back_to_idle", 512'(from_ctrl_tready), 512'(1));
    end
  endtask

  initial begin
    vec_t v;
    bit   ok;
    i_ap_rst_n = 1'b0;
    i_cluster_id = CLUSTER;
    i_KIP_port_number = PORT;
    from_ctrl_tvalid = 1'b0; from_ctrl_tdata = '0; from_ctrl_tkeep = '0; from_ctrl_tlast = 1'b0;
    from_ctrl_tdest = '0; from_ctrl_tuser = '0;
    to_WNN_tready = 1'b0;
    from_WNN_tvalid = 1'b0; from_WNN_tdata = '0; from_WNN_tdest = '0; from_WNN_tuser = 1'b0;
    to_nb_KIP_tready = 1'b0;

    tbl[0] = '{tdest: 32'hABCDABCD, ip: 32'h0A010868, data: {16{32'h12345678}}, refuse: 0,
               seq: 32'd3301, stall: 0, exp_req: 1, exp_drop: 0};
    tbl[1] = '{tdest: 32'hABCDABCD, ip: 32'h0A010868, data: {64{8'hA5}}, refuse: 2,
               seq: 32'd7, stall: 1, exp_req: 3, exp_drop: 0};
    tbl[2] = '{tdest: 32'h00C0FFEE, ip: 32'hC0A80001, data: {8{64'h0F0F_1E1E_2D2D_3C3C}}, refuse: 1000,
               seq: 32'd0, stall: 0, exp_req: MR, exp_drop: 1};
    tbl[3] = '{tdest: 32'h13572468, ip: 32'h0A000002, data: {32{16'hBEEF}}, refuse: 0,
               seq: 32'h0000_1234, stall: 20, exp_req: 1, exp_drop: 0};
    tbl[4] = '{tdest: 32'hFFFF0000, ip: 32'h7F000001, data: {512{1'b1}}, refuse: 0,
               seq: 32'hFFFFFFFF, stall: 2, exp_req: 1, exp_drop: 0};

    tick();
    tick();
    chk_reset_outputs();
    i_ap_rst_n = 1'b1;
    tick();
    chk("ctrl_rdy_after_rst", 512'(from_ctrl_tready), 512'(1));

    for (int i = 0; i < 5; i++) begin
      from_WNN_tvalid = 1'b1;
      chk("wnn_rdy_idle", 512'(from_WNN_tready), 512'(0));
      from_WNN_tvalid = 1'b0;
      xact(tbl[i]);
      tick();
    end

    // reset while the sequence request is outstanding
    from_ctrl_tvalid = 1'b1;
    from_ctrl_tdata  = tbl[0].data;
    from_ctrl_tdest  = tbl[0].tdest;
    from_ctrl_tuser  = {32'd0, tbl[0].ip};
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) if (from_ctrl_tready) ok = 1; else tick();
    tick();
    from_ctrl_tvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) if (to_WNN_tvalid) ok = 1; else tick();
    chk("rst_setup_req", 512'(ok), 512'(1));
    to_WNN_tready = 1'b1;
    tick();
    to_WNN_tready = 1'b0;
    chk("rst_setup_wait_seq", 512'(from_WNN_tready), 512'(1));
    #2 i_ap_rst_n = 1'b0;
    #1 chk_reset_outputs();
    tick();
    tick();
    i_ap_rst_n = 1'b1;
    tick();
    xact(tbl[0]);
    tick();

    for (int i = 0; i < 12; i++) begin
      v.tdest = $urandom();
      v.ip    = $urandom();
      for (int k = 0; k < 16; k++) v.data[k*32 +: 32] = $urandom();
      v.refuse   = $urandom_range(0, 4);
      v.seq      = $urandom();
      v.stall    = $urandom_range(0, 3);
      v.exp_drop = (v.refuse >= MR);
      v.exp_req  = v.exp_drop ? MR : v.refuse + 1;
      xact(v);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_kip_tx.md
# rpn_kip_tx

Transmit side of the reliable known-IP (KIP) path in the control API middleware. It accepts single-beat KIP messages from the Control module and obtains a per-destination sequence number from the WAN Node Number (WNN) block. It wraps each message in a PUB header (type, sender CTID, sequence number) and emits it on the Network Bridge KnownIP interface. It is the mirror of `rpn_KIP_RX`: every packet it emits is one that `rpn_KIP_RX` on the remote cluster can decode.

## Interface
Parameters (widths come from `ctrl_api_header_parameters.vh` / `ctrl_api_reliability_header_parameters.vh`):
- `RETRY_DELAY`, 16: idle cycles between a refused WNN request (lock = 0) and the next request.
- `MAX_RETRIES`, 255: number of refused requests after which the message is dropped.

Ports:
- `i_clk` in 1: single clock.
- `i_ap_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_cluster_id` in `AXIS_WAN_TDEST_WIDTH`: local CTID, written into the PUB sender-CTID field.
- `i_KIP_port_number` in `AXIS_KIP_TUSER_DEST_PORT_WIDTH`: UDP source and destination port.
- `from_ctrl_tvalid/tready/tdata/tkeep/tlast`: in/out/in/in/in, widths 1/1/`AXIS_DATA_WIDTH`/`AXIS_KEEP_WIDTH`/1. KIP message from Control.
- `from_ctrl_tdest` in `AXIS_WAN_TDEST_WIDTH`: destination CTID.
- `from_ctrl_tuser` in `AXIS_KIP_TUSER_WIDTH`: destination IP in the low `IP_ADDRESS_WIDTH` bits.
- `to_WNN_tvalid/tready/tdata/tdest`: out/in/out/out, widths 1/1/`RPN_MSG_TYPE_WIDTH`/`AXIS_WAN_TDEST_WIDTH`. Sequence-number request.
- `from_WNN_tvalid/tready/tdata/tdest/tuser`: in/out/in/in/in, widths 1/1/`WAN_SEQUENCE_NUMBER_WIDTH`/`AXIS_WAN_TDEST_WIDTH`/1. Grant: sequence number, CTID, lock (1 = granted).
- `to_nb_KIP_tvalid/tready/tdata/tkeep/tuser/tlast`: out/in/out/out/out/out, widths 1/1/`AXIS_DATA_WIDTH`/`AXIS_KEEP_WIDTH`/`AXIS_KIP_TUSER_WIDTH`/1. PUB packet to the Network Bridge.
- `o_drop` out 1: one-cycle pulse when a message is abandoned.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT_SEQ`, `BACKOFF`, `SEND`.
- `IDLE`: `from_ctrl_tready`=1. On handshake, latch tdata, tdest and tuser; clear the retry count; go to `REQ`.
  - Messages are single-beat; tlast is ignored and tkeep is not forwarded.
- `REQ`: `to_WNN_tvalid`=1, tdata = `RPN_MSG_TYPE_KIP_PUB`, tdest = latched CTID. On handshake go to `WAIT_SEQ`.
- `WAIT_SEQ`: `from_WNN_tready`=1. On handshake:
  - tuser=1: latch the sequence number; go to `SEND`.
  - tuser=0: increment the retry count. If the count equals `MAX_RETRIES`, pulse `o_drop` and go to `IDLE`; otherwise go to `BACKOFF`.
  - `from_WNN_tdest` is not checked; one request is outstanding at a time.
- `BACKOFF`: count `RETRY_DELAY` cycles, then go to `REQ`.
- `SEND`: `to_nb_KIP_tvalid`=1 and held stable until tready. On handshake go to `IDLE`. PUB packet contents:
  - tdata[`RPN_MSG_TYPE_WIDTH`-1:0] = `RPN_MSG_TYPE_KIP_PUB`.
  - `PUB_KIP_SENDER_CTID` field = `i_cluster_id`.
  - `PUB_KIP_SEQUENCE_NUMBER` field = granted sequence number.
  - The low (`AXIS_DATA_WIDTH` − `PUB_KIP_DATA_OFFSET`) bits of the latched message are placed at `PUB_KIP_DATA_OFFSET`; upper message bits are discarded. All other bits are 0.
  - tkeep all ones; tlast = 1.
  - tuser: IP = latched IP; DEST_PORT and SRC_PORT = `i_KIP_port_number`; all other bits 0.
- The sequence number is used exactly as granted; the block performs no arithmetic on it, so wrap-around is owned by WNN.

## Timing
- Reset values: all tvalid = 0, all tready = 0, `o_drop` = 0, state `IDLE`, all data registers 0.
- Reset asserted mid-transaction discards the message; no partial output is produced.
- Latency, all outputs registered:
  - ctrl handshake at cycle 0 → `to_WNN_tvalid` at cycle 1.
  - WNN grant handshake at cycle N → `to_nb_KIP_tvalid` at cycle N+1.
- Throughput: one message per ≥4 cycles when WNN answers in 1 cycle. `from_ctrl_tready` is 0 outside `IDLE`.
- Backpressure: in `REQ` and `SEND`, valid and data are stable until tready.
- `from_WNN` beats arriving outside `WAIT_SEQ` are not accepted (tready = 0).
- `o_drop` is high in the cycle after the final refused grant is accepted.

## Structure
- FSM state enum, `RETRY_DELAY`/`MAX_RETRIES` defaults and the PUB field offsets belong in the shared reliability header, `ctrl_api_reliability_header_parameters.vh`, which `rpn_KIP_RX` also uses.
- No sub-module: FSM, header packing and the backoff counter live in a single module.

## Test plan
All scenarios use `i_cluster_id` = 'hEAEAEAEA and `i_KIP_port_number` = 'hFB.
1. Ctrl beat with tdest 'hABCDABCD and IP 'h0A010868; WNN grants seq 3301, lock 1 → one to_nb_KIP beat: type `KIP_PUB`, sender CTID 'hEAEAEAEA, seq 3301, payload at `PUB_KIP_DATA_OFFSET`, both ports 'hFB, IP 'h0A010868.
2. Same message; WNN refuses twice, then grants seq 7 → exactly three to_WNN requests, each after `RETRY_DELAY` idle cycles, then one PUB with seq 7.
3. `MAX_RETRIES`=3 and WNN always refuses → three requests, one `o_drop` pulse, no to_nb_KIP beat, block returns to `IDLE`.
4. `to_nb_KIP_tready` held 0 for 20 cycles → tvalid and tdata stable throughout; `from_ctrl_tready` stays 0; one beat on release.
5. Reset asserted while in `WAIT_SEQ` → all outputs take reset values immediately; the next message is processed normally.
6. WNN grants seq = all ones (maximum value) → the field carries exactly that value, with no change to neighbouring fields.
